router_fsm: RTL and testbench

//  Control FSM for the 1x3 packet router input side: decodes the 2-bit destination

---
 rtl/router_fsm.sv | 137 +++++++++++++
 tb/tb_router_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// router_fsm: input-side control FSM for a 1x3 packet router.
// Decodes the 2-bit destination address, sequences header/payload/parity
// loading into the register block and the addressed output FIFO, and stalls
// the source while the FIFO is full or not yet drained.
// Outputs are registered from the next state, so each flag is valid in the
// same cycle the FSM occupies the corresponding state.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       parity_done,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] addr;

  logic       empty_in;    // empty flag of the FIFO named by data_in
  logic       empty_addr;  // empty flag of the FIFO latched in addr
  logic       soft_hit;    // timeout on the FIFO this packet is routed to

  // Select per-FIFO status by the incoming and the latched address.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    empty_in   = 1'b0;
    empty_addr = 1'b0;
    soft_hit   = 1'b0;
    case (data_in)
      2'd0:    empty_in = fifo_empty_0;
      2'd1:    empty_in = fifo_empty_1;
      2'd2:    empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
    case (addr)
      2'd0: begin empty_addr = fifo_empty_0; soft_hit = soft_reset_0; end
      2'd1: begin empty_addr = fifo_empty_1; soft_hit = soft_reset_1; end
      2'd2: begin empty_addr = fifo_empty_2; soft_hit = soft_reset_2; end
      default: begin empty_addr = 1'b0; soft_hit = 1'b0; end
    endcase
  end

  // Next-state rules; a timeout on the addressed FIFO aborts from any state.
  always_comb begin
    next_state = state;
    if (soft_hit) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && (data_in != 2'd3))
            next_state = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        FIFO_FULL_STATE: begin
          if (!fifo_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) next_state = LOAD_PARITY;
          else                    next_state = LOAD_DATA;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_addr) next_state = LOAD_FIRST_DATA;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // State, address capture and registered Moore outputs decoded from next_state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (resetn) begin
      state        <= DECODE_ADDRESS;
      addr         <= 2'd0;
      busy         <= 1'b0;
      detect_add   <= 1'b1;
      lfd_state    <= 1'b0;
      ld_state     <= 1'b0;
      laf_state    <= 1'b0;
      full_state   <= 1'b0;
      write_en_reg <= 1'b0;
      rst_int_reg  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS)
        addr <= data_in;
      busy         <= !((next_state == DECODE_ADDRESS) || (next_state == LOAD_DATA));
      detect_add   <= (next_state == DECODE_ADDRESS);
      lfd_state    <= (next_state == LOAD_FIRST_DATA);
      ld_state     <= (next_state == LOAD_DATA);
      laf_state    <= (next_state == LOAD_AFTER_FULL);
      full_state   <= (next_state == FIFO_FULL_STATE);
      write_en_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                      (next_state == LOAD_AFTER_FULL);
      rst_int_reg  <= (next_state == CHECK_PARITY_ERROR);
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed packet scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the router control rules.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;
  logic       low_pkt_valid;
  logic       parity_done;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_en_reg, rst_int_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
    .rst_int_reg(rst_int_reg)
  );

  // Reference model: named phases of packet handling.
  typedef enum int { P_DECODE, P_HEADER, P_PAYLOAD, P_PARITY, P_FULL,
                     P_AFTER_FULL, P_WAIT, P_CHECK } phase_t;

  phase_t m_phase;
  int     m_dest;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Output vector {busy,detect,lfd,ld,laf,full,wen,rst_int} seen in a phase.
  function automatic logic [7:0] expect_out(phase_t p);
    logic stall, writing;
    stall   = !(p == P_DECODE || p == P_PAYLOAD);
    writing = (p == P_PAYLOAD || p == P_PARITY || p == P_AFTER_FULL);
    return {stall, p == P_DECODE, p == P_HEADER, p == P_PAYLOAD,
            p == P_AFTER_FULL, p == P_FULL, writing, p == P_CHECK};
  endfunction

  function automatic logic [7:0] dut_out();
    return {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
            write_en_reg, rst_int_reg};
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit     empties[3];
    bit     timeouts[3];
    phase_t nxt;
    empties  = '{fifo_empty_0, fifo_empty_1, fifo_empty_2};
    timeouts = '{soft_reset_0, soft_reset_1, soft_reset_2};
    if (resetn) begin
      m_phase = P_DECODE;
      m_dest  = 0;
      return;
    end
    nxt = m_phase;
    if (m_dest < 3 && timeouts[m_dest]) nxt = P_DECODE;
    else if (m_phase == P_DECODE) begin
      if (pkt_valid && int'(data_in) < 3)
        nxt = empties[data_in] ? P_HEADER : P_WAIT;
    end
    else if (m_phase == P_HEADER)     nxt = P_PAYLOAD;
    else if (m_phase == P_PAYLOAD)    nxt = fifo_full ? P_FULL : (pkt_valid ? P_PAYLOAD : P_PARITY);
    else if (m_phase == P_PARITY)     nxt = P_CHECK;
    else if (m_phase == P_CHECK)      nxt = fifo_full ? P_FULL : P_DECODE;
    else if (m_phase == P_FULL)       nxt = fifo_full ? P_FULL : P_AFTER_FULL;
    else if (m_phase == P_AFTER_FULL) nxt = parity_done ? P_DECODE :
                                            (low_pkt_valid ? P_PARITY : P_PAYLOAD);
    else if (m_phase == P_WAIT)       nxt = empties[m_dest] ? P_HEADER : P_WAIT;
    if (m_phase == P_DECODE) m_dest = int'(data_in);
    m_phase = nxt;
  endtask

  // One clock: model sees the same inputs the DUT samples; compare after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag, dut_out(), expect_out(m_phase));
  endtask

  task automatic idle_inputs();
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b1;
    tick("reset");
    check("reset_const", dut_out(), 8'b0100_0000);
    resetn = 1'b0;
  endtask

  // Drive the header of a packet to address a and step into LOAD_DATA.
  task automatic start_packet(input logic [1:0] a);
    pkt_valid = 1'b1; data_in = a;
    tick("hdr");
    tick("first_payload");
    check("in_ld", dut_out(), 8'b0001_0010);
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();

    // 1: normal packet to FIFO 1, parity, back to decode.
    start_packet(2'd1);
    tick("s1_ld_hold");
    pkt_valid = 1'b0;
    tick("s1_parity");
    check("s1_parity_const", dut_out(), 8'b1000_0010);
    tick("s1_check");
    check("s1_check_const", dut_out(), 8'b1000_0001);
    tick("s1_decode");

    // 2: full during payload, resume into parity via low_pkt_valid.
    start_packet(2'd1);
    fifo_full = 1'b1;
    tick("s2_full");
    check("s2_full_const", dut_out(), 8'b1000_0100);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    tick("s2_laf");
    tick("s2_parity");
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    tick("s2_check");
    tick("s2_decode");

    // 3: full during payload, resume back into payload.
    start_packet(2'd0);
    fifo_full = 1'b1;
    tick("s3_full");
    fifo_full = 1'b0;
    tick("s3_laf");
    tick("s3_ld");
    pkt_valid = 1'b0;
    tick("s3_parity");
    tick("s3_check");
    tick("s3_decode");

    // 4: full on parity check, parity already stored.
    start_packet(2'd2);
    pkt_valid = 1'b0;
    tick("s4_parity");
    fifo_full = 1'b1;
    tick("s4_check");
    tick("s4_full");
    fifo_full = 1'b0; parity_done = 1'b1;
    tick("s4_laf");
    tick("s4_decode");
    parity_done = 1'b0;

    // 5: destination FIFO not empty -> wait, then header.
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
    tick("s5_wait");
    check("s5_wait_const", dut_out(), 8'b1000_0000);
    data_in = 2'd0;
    tick("s5_wait_hold");
    fifo_empty_1 = 1'b1;
    tick("s5_header");
    tick("s5_ld");
    pkt_valid = 1'b0;
    tick("s5_parity");
    tick("s5_check");
    tick("s5_decode");

    // 6: timeouts, invalid address, reset mid-packet.
    start_packet(2'd1);
    soft_reset_2 = 1'b1;
    tick("s6_sr2_ignored");
    soft_reset_2 = 1'b0; soft_reset_1 = 1'b1;
    tick("s6_sr1_abort");
    check("s6_abort_const", dut_out(), 8'b0100_0000);
    soft_reset_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'd3;
    tick("s6_addr3_a");
    tick("s6_addr3_b");
    start_packet(2'd2);
    resetn = 1'b1;
    tick("s6_reset_mid");
    check("s6_reset_const", dut_out(), 8'b0100_0000);
    resetn = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      resetn        = ($urandom_range(99) < 1);
      pkt_valid     = ($urandom_range(99) < 70);
      data_in       = 2'($urandom_range(3));
      fifo_empty_0  = ($urandom_range(99) < 60);
      fifo_empty_1  = ($urandom_range(99) < 60);
      fifo_empty_2  = ($urandom_range(99) < 60);
      soft_reset_0  = ($urandom_range(99) < 4);
      soft_reset_1  = ($urandom_range(99) < 4);
      soft_reset_2  = ($urandom_range(99) < 4);
      fifo_full     = ($urandom_range(99) < 30);
      low_pkt_valid = ($urandom_range(99) < 40);
      parity_done   = ($urandom_range(99) < 30);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
